// File: rtl/waveform_phase_gen.sv
// Phase-accumulator address generator for the waveform shaper stage.
// A wide accumulator steps by the active frequency word once per sample tick.
// Its top 10 bits are presented as the table address.
// Frequency, duty and divider updates are held in a shadow copy. They take
// effect only at a period wrap, when the accumulator is idle (fcw==0), or
// while the block is disabled, so the shaper never sees a torn period.
//
// Strobe semantics: o_valid is a one-cycle, no-backpressure strobe. It is high
// in the cycle after a tick, and o_addr/o_sel/o_wrap are meaningful in that
// cycle. There is no ready; the downstream stage must accept every strobe.
module waveform_phase_gen #(
  parameter int ACC_W = 24,
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [ACC_W-1:0] i_fcw,
  input  logic [3:0]       i_sel,
  input  logic [DIV_W-1:0] i_div,
  output logic [9:0]       o_addr,
  output logic [3:0]       o_sel,
  output logic             o_valid,
  output logic             o_wrap,
  output logic             o_busy
);

  logic [ACC_W-1:0] acc;
  logic [DIV_W-1:0] div_cnt;

  logic [ACC_W-1:0] fcw_act;
  logic [DIV_W-1:0] div_act;

  logic [ACC_W-1:0] fcw_sh;
  logic [DIV_W-1:0] div_sh;
  logic [3:0]       sel_sh;
  logic             pending;

  logic [3:0]       sel_clamp;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             tick;
  logic             commit;
  logic [ACC_W-1:0] fcw_nxt;
  logic [DIV_W-1:0] div_nxt;
  logic [3:0]       sel_nxt;

  // Tick and commit decode. A commit only matters when there is something to
  // take: a pending shadow or a load arriving on the same edge (bypass).
  always_comb begin
    sel_clamp = (i_sel > 4'd10) ? 4'd10 : i_sel;
    sum       = {1'b0, acc} + {1'b0, fcw_act};
    carry     = sum[ACC_W];
    tick      = i_en && (div_cnt == div_act);
    commit    = (pending || i_load) &&
                ((tick && (carry || (fcw_act == '0))) || !i_en);
    fcw_nxt   = i_load ? i_fcw     : fcw_sh;
    div_nxt   = i_load ? i_div     : div_sh;
    sel_nxt   = i_load ? sel_clamp : sel_sh;
  end

  // Shadow parameter capture and the pending flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fcw_sh  <= '0;
      div_sh  <= '0;
      sel_sh  <= '0;
      pending <= 1'b0;
    end else begin
      if (i_load) begin
        fcw_sh <= i_fcw;
        div_sh <= i_div;
        sel_sh <= sel_clamp;
      end
      if (commit) begin
        pending <= 1'b0;
      end else if (i_load) begin
        pending <= 1'b1;
      end
    end
  end

  // Active parameters; o_sel changes on the same edge as the wrapping sample.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fcw_act <= '0;
      div_act <= '0;
      o_sel   <= '0;
    end else if (commit) begin
      fcw_act <= fcw_nxt;
      div_act <= div_nxt;
      o_sel   <= sel_nxt;
    end
  end

  // Sample-rate divider: restarts on a tick or a commit, holds when disabled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_cnt <= '0;
    end else if (tick || commit) begin
      div_cnt <= '0;
    end else if (i_en) begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Accumulator step and sample strobes; the wrapping sample uses the old fcw.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc     <= '0;
      o_addr  <= '0;
      o_valid <= 1'b0;
      o_wrap  <= 1'b0;
    end else begin
      o_valid <= tick;
      o_wrap  <= tick && carry;
      if (tick) begin
        acc    <= sum[ACC_W-1:0];
        o_addr <= sum[ACC_W-1 -: 10];
      end
    end
  end

  assign o_busy = pending;

endmodule
